// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding,
// default operand width and iteration-counter sizing.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  // Counter must hold 0..WIDTH-1; never narrower than one bit.
  function automatic int count_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/shift_add_mult_add_row.sv
// One row of WIDTH ripple-carry full-adder cells; purely combinational.
module add_row #(
  parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = x[i] ^ y[i] ^ carry[i];
    assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned radix-2 shift-and-add multiplier, one partial-product
// row per clock, WIDTH iterations per product, start/done handshake.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  // Handshake: start is accepted only while idle (busy=0); done pulses for
  // exactly one cycle and product stays valid until the next accept or rst.

  localparam int CW = count_width(WIDTH);

  mult_state_e        state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   row_sum;
  logic               row_cout;
  logic [2*WIDTH-1:0] acc_next;

  add_row #(.WIDTH(WIDTH)) u_add_row (
    .x    (acc_q[2*WIDTH-1:WIDTH]),
    .y    (mcand_q),
    .cin  (1'b0),
    .sum  (row_sum),
    .cout (row_cout)
  );

  // Right shift keeps the adder carry as the new MSB.
  always_comb begin
    if (acc_q[0]) acc_next = {row_cout, row_sum, acc_q[WIDTH-1:1]};
    else          acc_next = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          acc_d   = {{WIDTH{1'b0}}, b};
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_next;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          product_d = acc_next;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule
